spi_slave_sync: RTL
===================

# spi_slave_sync

System-clocked SPI mode-0 slave (responder) that sits opposite `spi_master` on the `sclk`/`mosi`/`miso`/`cs` wires. All SPI pins are synchronised into `clk` and edge-detected, so the parallel side runs in the system clock domain. The block receives MSB-first bytes from `mosi` and returns host-supplied bytes on `miso`. It uses a one-deep transmit holding register with a valid/ready handshake.

## Interface
- `DATA_W`, 8: bits per SPI word.
- `SYNC_STAGES`, 2: flops in each input synchroniser (≥2).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`, idle low.
- `cs`  in  1  chip select, active-low, asynchronous.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master.
- `tx_data`  in  DATA_W  word to send in a later SPI word slot.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  holding register empty; transfer occurs when `tx_valid && tx_ready` at a rising `clk` edge.
- `rx_data`  out  DATA_W  last complete received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.

## Operation
- `sclk`, `cs` and `mosi` each pass through a `SYNC_STAGES` flop chain. One further flop on synced `sclk` and on synced `cs` provides edge detection: `rise`, `fall`, `cs_fall`, `cs_rise`.
- FSM states:
  - IDLE (synced `cs` high).
  - ACTIVE (synced `cs` low).
  - Transition IDLE→ACTIVE on `cs_fall`; ACTIVE→IDLE on `cs_rise`.
- Load on entry to ACTIVE: the tx shift register loads from the holding register if it is full, else from all-zeros. The holding register is marked empty. `bit_cnt` is set to 0.
- ACTIVE, `rise`: `rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}`; `bit_cnt` increments.
- ACTIVE, `rise` with `bit_cnt == DATA_W-1`:
  - `rx_data` is set to the completed word and `rx_valid` is pulsed.
  - `bit_cnt` wraps to 0 and `word_done` is set.
- ACTIVE, `fall`:
  - If `word_done` is set, reload the tx shift register (holding register or zeros, as above), mark the holding register empty and clear `word_done`.
  - Otherwise shift the tx register left by one.
- `miso` = tx shift MSB while ACTIVE.
- Handshake:
  - `tx_ready = !hold_full`.
  - An accept in the same cycle as a load is not bypassed. The load takes the old contents (or zeros), and the new word is held for the next slot.
- `cs_rise` mid-word: the partial word is discarded, with no `rx_valid`. `bit_cnt` and `word_done` clear. The holding register is untouched.
- `rise` or `fall` while IDLE: ignored.
- Reset values:
  - `miso` = 0, `tx_ready` = 1, `rx_data` = 0, `rx_valid` = 0.
  - State IDLE, `bit_cnt` = 0, holding register empty.
  - All synchroniser flops 0, with `cs` flops 1.
- Reset mid-transfer: returns to the reset values immediately. The block stays IDLE until a fresh `cs_fall` is seen.

## Timing
- Pin-to-detect latency: `SYNC_STAGES`+1 `clk` cycles.
- `rx_valid` rises on the `clk` edge after the cycle in which the final `rise` is detected. It is high for exactly 1 cycle.
- `miso` updates 1 cycle after the detected `fall` or `cs_fall`.
- Constraints on the master:
  - Each `sclk` phase ≥ `SYNC_STAGES`+2 `clk` periods.
  - `cs` low-to-first-`sclk`-rise ≥ `SYNC_STAGES`+2 `clk` periods.
- `tx_ready` rises 1 cycle after a load empties the holding register.

## Configuration
- `SPI_SLAVE_SYNC_MISO_TRISTATE_EN`:
  - Defined: `miso` is driven `1'bz` while IDLE and during reset, allowing multiple slaves on one `miso` line.
  - Undefined: `miso` is driven 0 while IDLE. ACTIVE behaviour is identical in both cases.

## Test plan
- Reset, then one 8-bit transfer with master sending 0xA5 and holding register empty → `rx_data`=0xA5 with a single `rx_valid` pulse; master reads 0x00.
- `tx_data`=0x3C accepted while IDLE (`tx_ready` drops), then an 8-bit transfer → master reads 0x3C; `tx_ready` returns high 1 cycle after `cs_fall` is detected.
- Continuous two-word burst (`cs` held low): master sends 0x12, 0x34; 0xC3 is accepted during word 1 → two `rx_valid` pulses with 0x12 then 0x34; master reads 0x00 then 0xC3.
- `cs` deasserted after 5 bits, then a full transfer of 0x81 → no `rx_valid` for the partial word; next `rx_data`=0x81.
- `reset` asserted after 3 bits of 0xFF → all outputs at reset values; the next full transfer of 0x5A gives `rx_data`=0x5A.
- `tx_valid` asserted in the same cycle as `cs_fall` detection with 0x77 → current word sends 0x00; the next word sends 0x77. With the macro defined, `miso` reads Z while `cs` is high.

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: clk-domain SPI mode-0 slave with MSB-first shifting and a one-deep tx holding register.
// Ports: clk/reset (sync, active-high); sclk, cs (active-low), mosi from the master; miso to the master;
//        tx_data/tx_valid/tx_ready: word for a later slot; rx_data/rx_valid: last received word plus a 1-cycle pulse.
// Option: SPI_SLAVE_SYNC_MISO_TRISTATE_EN drives miso to 1'bz while IDLE or in reset instead of 0.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic [DATA_W-1:0] tx_shift, hold, rx_next;
  logic [DATA_W-2:0] rx_shift;
  logic [CW-1:0] bit_cnt;
  logic hold_full, word_done;
  logic rise, fall, cs_fall, cs_rise, enter, leave, act, load, last_bit;
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      cs_d   <= cs_s[SYNC_STAGES-1];
    end
  end
  assign rise     = sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign fall     = ~sclk_s[SYNC_STAGES-1] & sclk_d;
  assign cs_fall  = ~cs_s[SYNC_STAGES-1] & cs_d;
  assign cs_rise  = cs_s[SYNC_STAGES-1] & ~cs_d;
  assign last_bit = bit_cnt == CW'(DATA_W - 1);
  assign rx_next  = {rx_shift, mosi_s[SYNC_STAGES-1]};
  always_ff @(posedge clk) state <= reset ? IDLE : next_state;
  always_comb begin
    next_state = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
    enter      = state == IDLE && cs_fall;
    leave      = state == ACTIVE && cs_rise;
    act        = state == ACTIVE && !cs_rise;
    // a word boundary reload happens on the first fall after the last rise
    load       = enter || (act && fall && word_done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
      bit_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (load) tx_shift <= hold_full ? hold : '0;
      else if (act && fall) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (enter || leave) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (act && rise) begin
        rx_shift <= rx_next[DATA_W-2:0];
        bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
        if (last_bit) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          word_done <= 1'b1;
        end
      end else if (load) word_done <= 1'b0;
      // accept only when empty, so a same-cycle load already took zeros and the new word waits
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) hold_full <= 1'b0;
    end
  end
  assign tx_ready = !hold_full;
`ifdef SPI_SLAVE_SYNC_MISO_TRISTATE_EN
  assign miso = (state == ACTIVE && !reset) ? tx_shift[DATA_W-1] : 1'bz;
`else
  assign miso = (state == ACTIVE && !reset) ? tx_shift[DATA_W-1] : 1'b0;
`endif
endmodule
